// File: rtl/mem_dispatch_pkg.sv
// Shared encodings and helpers for the MEM-stage load/store dispatcher.
package mem_dispatch_pkg;

    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;

    localparam logic REQ_READ  = 1'b0;
    localparam logic REQ_WRITE = 1'b1;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;
    localparam logic [1:0] SIZE_D = 2'd3;

    localparam logic [1:0] RESP_OK = 2'd0;

    localparam logic [ADDR_W-1:0] CLINT_BASE_DEF = 64'h0000_0000_0200_0000;
    localparam logic [ADDR_W-1:0] CLINT_MASK_DEF = 64'hFFFF_FFFF_FFFF_0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLINT,
        ST_BUS,
        ST_RESP
    } state_t;

    // An access is misaligned when any address bit below its natural size is set.
    function automatic logic is_misaligned(input logic [2:0] offset, input logic [1:0] size);
        case (size)
            SIZE_B:  return 1'b0;
            SIZE_H:  return offset[0];
            SIZE_W:  return |offset[1:0];
            default: return |offset;
        endcase
    endfunction

    // Byte-enable pattern for an access of the given size at lane 0.
    function automatic logic [7:0] size_mask(input logic [1:0] size);
        case (size)
            SIZE_B:  return 8'h01;
            SIZE_H:  return 8'h03;
            SIZE_W:  return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/mem_dispatch_if.sv
// Pipeline, CLINT and data-bus bridge signals of the dispatcher.
// The slave view is the dispatcher itself; the master view is its surroundings.
interface mem_dispatch_if;
    import mem_dispatch_pkg::*;

    logic              mem_valid_i;
    logic              mem_req_i;
    logic [1:0]        mem_size_i;
    logic              mem_unsigned_i;
    logic [ADDR_W-1:0] mem_addr_i;
    logic [DATA_W-1:0] mem_wdata_i;
    logic              mem_done_o;
    logic [DATA_W-1:0] mem_rdata_o;
    logic              mem_err_o;
    logic              mem_stall_o;

    logic              clint_valid_o;
    logic              clint_req_o;
    logic [ADDR_W-1:0] clint_addr_o;
    logic [1:0]        clint_size_o;
    logic [DATA_W-1:0] clint_wdata_o;
    logic              clint_ready_i;
    logic [DATA_W-1:0] clint_rdata_i;
    logic [1:0]        clint_resp_i;

    logic              bus_valid_o;
    logic              bus_req_o;
    logic [ADDR_W-1:0] bus_addr_o;
    logic [1:0]        bus_size_o;
    logic [DATA_W-1:0] bus_wdata_o;
    logic [7:0]        bus_strb_o;
    logic              bus_ready_i;
    logic [DATA_W-1:0] bus_rdata_i;
    logic [1:0]        bus_resp_i;

    modport slave (
        input  mem_valid_i, mem_req_i, mem_size_i, mem_unsigned_i, mem_addr_i, mem_wdata_i,
        output mem_done_o, mem_rdata_o, mem_err_o, mem_stall_o,
        output clint_valid_o, clint_req_o, clint_addr_o, clint_size_o, clint_wdata_o,
        input  clint_ready_i, clint_rdata_i, clint_resp_i,
        output bus_valid_o, bus_req_o, bus_addr_o, bus_size_o, bus_wdata_o, bus_strb_o,
        input  bus_ready_i, bus_rdata_i, bus_resp_i
    );

    modport master (
        output mem_valid_i, mem_req_i, mem_size_i, mem_unsigned_i, mem_addr_i, mem_wdata_i,
        input  mem_done_o, mem_rdata_o, mem_err_o, mem_stall_o,
        input  clint_valid_o, clint_req_o, clint_addr_o, clint_size_o, clint_wdata_o,
        output clint_ready_i, clint_rdata_i, clint_resp_i,
        input  bus_valid_o, bus_req_o, bus_addr_o, bus_size_o, bus_wdata_o, bus_strb_o,
        output bus_ready_i, bus_rdata_i, bus_resp_i
    );

endinterface

// File: rtl/mem_load_align.sv
// Extracts the addressed bytes from a 64-bit beat and sign/zero-extends them.
module mem_load_align
    import mem_dispatch_pkg::*;
(
    input  logic [DATA_W-1:0] rdata,
    input  logic [2:0]        offset,
    input  logic [1:0]        size,
    input  logic              is_unsigned,
    output logic [DATA_W-1:0] data
);

    logic [DATA_W-1:0] shifted;

    // Right-justify the addressed lane, then truncate and extend to the access size.
    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        case (size)
            SIZE_B:  data = is_unsigned ? {56'd0, shifted[7:0]}  : {{56{shifted[7]}},  shifted[7:0]};
            SIZE_H:  data = is_unsigned ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
            SIZE_W:  data = is_unsigned ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/mem_dispatch.sv
// MEM-stage dispatcher: routes each load/store to the CLINT or the data-bus bridge.
module mem_dispatch
    import mem_dispatch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] CLINT_BASE = CLINT_BASE_DEF,
    parameter logic [ADDR_W-1:0] CLINT_MASK = CLINT_MASK_DEF
) (
    input logic           clk,
    input logic           rst,
    mem_dispatch_if.slave io
);

    state_t            state;
    state_t            next_state;
    logic              req_q;
    logic [1:0]        size_q;
    logic              unsigned_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              misaligned_q;
    logic              clint_path_q;
    logic [DATA_W-1:0] rdata_q;
    logic [1:0]        resp_q;
    logic              accept;
    logic              misaligned_now;
    logic              clint_hit;
    logic              done;
    logic [DATA_W-1:0] load_data;

    assign accept         = (state == ST_IDLE) && io.mem_valid_i;
    assign misaligned_now = is_misaligned(io.mem_addr_i[2:0], io.mem_size_i);
    assign clint_hit      = (io.mem_addr_i & CLINT_MASK) == CLINT_BASE;

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    // Next-state decode plus the per-state strobes.
    always_comb begin
        next_state       = state;
        io.clint_valid_o = 1'b0;
        io.bus_valid_o   = 1'b0;
        done             = 1'b0;
        case (state)
            ST_IDLE: begin
                if (io.mem_valid_i) begin
                    if (misaligned_now) next_state = ST_RESP;
                    else if (clint_hit) next_state = ST_CLINT;
                    else                next_state = ST_BUS;
                end
            end
            ST_CLINT: begin
                io.clint_valid_o = 1'b1;
                if (io.clint_ready_i) next_state = ST_RESP;
            end
            ST_BUS: begin
                io.bus_valid_o = 1'b1;
                if (io.bus_ready_i) next_state = ST_RESP;
            end
            default: begin
                done       = 1'b1;
                next_state = ST_IDLE;
            end
        endcase
    end

    // Latch the request on acceptance and capture the downstream response on completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_q        <= REQ_READ;
            size_q       <= SIZE_B;
            unsigned_q   <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            misaligned_q <= 1'b0;
            clint_path_q <= 1'b0;
            rdata_q      <= '0;
            resp_q       <= RESP_OK;
        end else if (accept) begin
            req_q        <= io.mem_req_i;
            size_q       <= io.mem_size_i;
            unsigned_q   <= io.mem_unsigned_i;
            addr_q       <= io.mem_addr_i;
            wdata_q      <= io.mem_wdata_i;
            misaligned_q <= misaligned_now;
            clint_path_q <= clint_hit;
            rdata_q      <= '0;
            resp_q       <= RESP_OK;
        end else if (state == ST_CLINT && io.clint_ready_i) begin
            rdata_q <= io.clint_rdata_i;
            resp_q  <= io.clint_resp_i;
        end else if (state == ST_BUS && io.bus_ready_i) begin
            rdata_q <= io.bus_rdata_i;
            resp_q  <= io.bus_resp_i;
        end
    end

    // CLINT returns its register right-justified, so only bus beats need lane selection.
    mem_load_align u_align (
        .rdata       (rdata_q),
        .offset      (clint_path_q ? 3'd0 : addr_q[2:0]),
        .size        (size_q),
        .is_unsigned (unsigned_q),
        .data        (load_data)
    );

    assign io.mem_done_o  = done;
    assign io.mem_rdata_o = (done && req_q == REQ_READ && !misaligned_q) ? load_data : '0;
    assign io.mem_err_o   = done && (misaligned_q || resp_q != RESP_OK);
    assign io.mem_stall_o = io.mem_valid_i && !done;

    assign io.clint_req_o   = req_q;
    assign io.clint_addr_o  = addr_q;
    assign io.clint_size_o  = size_q;
    assign io.clint_wdata_o = wdata_q;

    assign io.bus_req_o   = req_q;
    assign io.bus_addr_o  = {addr_q[ADDR_W-1:3], 3'b000};
    assign io.bus_size_o  = size_q;
    assign io.bus_strb_o  = (req_q == REQ_WRITE) ? (size_mask(size_q) << addr_q[2:0]) : 8'h00;
    assign io.bus_wdata_o = (req_q == REQ_WRITE) ? (wdata_q << {addr_q[2:0], 3'b000}) : '0;

endmodule

// File: tb/tb_mem_dispatch.sv
// Directed testbench for mem_dispatch with hand-computed expectations.
module tb_mem_dispatch;
    import mem_dispatch_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    mem_dispatch_if io ();

    mem_dispatch dut (
        .clk (clk),
        .rst (rst),
        .io  (io.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic req, input logic [1:0] size, input logic uns,
                             input logic [63:0] addr, input logic [63:0] wdata);
        io.mem_valid_i    = 1'b1;
        io.mem_req_i      = req;
        io.mem_size_i     = size;
        io.mem_unsigned_i = uns;
        io.mem_addr_i     = addr;
        io.mem_wdata_i    = wdata;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        vectors++;
        if (io.mem_done_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done got=%0h exp=0", io.mem_done_o); end
        vectors++;
        if (io.mem_err_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_err got=%0h exp=0", io.mem_err_o); end
        vectors++;
        if (io.mem_rdata_o !== 64'd0) begin miscompares++; $display("[TB] FAIL reset_rdata got=%0h exp=0", io.mem_rdata_o); end
        vectors++;
        if (io.clint_valid_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_clint_valid got=%0h exp=0", io.clint_valid_o); end
        vectors++;
        if (io.bus_valid_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_bus_valid got=%0h exp=0", io.bus_valid_o); end
        vectors++;
        if (io.bus_strb_o !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_bus_strb got=%0h exp=0", io.bus_strb_o); end
        vectors++;
        if (io.bus_addr_o !== 64'd0) begin miscompares++; $display("[TB] FAIL reset_bus_addr got=%0h exp=0", io.bus_addr_o); end
        vectors++;
        if (io.mem_stall_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_stall got=%0h exp=0", io.mem_stall_o); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_clint_read();
        io.clint_ready_i = 1'b1;
        io.clint_rdata_i = 64'h0000_0001_8000_0001;
        io.clint_resp_i  = 2'd0;
        drive_req(REQ_READ, SIZE_W, 1'b0, 64'h0000_0000_0200_BFF8, 64'd0);
        tick();
        vectors++;
        if (io.clint_valid_o !== 1'b1) begin miscompares++; $display("[TB] FAIL clint_valid got=%0h exp=1", io.clint_valid_o); end
        vectors++;
        if (io.bus_valid_o !== 1'b0) begin miscompares++; $display("[TB] FAIL clint_no_bus got=%0h exp=0", io.bus_valid_o); end
        vectors++;
        if (io.clint_addr_o !== 64'h0000_0000_0200_BFF8) begin miscompares++; $display("[TB] FAIL clint_addr got=%0h exp=200bff8", io.clint_addr_o); end
        vectors++;
        if (io.mem_done_o !== 1'b0) begin miscompares++; $display("[TB] FAIL clint_early_done got=%0h exp=0", io.mem_done_o); end
        vectors++;
        if (io.mem_stall_o !== 1'b1) begin miscompares++; $display("[TB] FAIL clint_stall got=%0h exp=1", io.mem_stall_o); end
        tick();
        vectors++;
        if (io.mem_done_o !== 1'b1) begin miscompares++; $display("[TB] FAIL clint_done got=%0h exp=1", io.mem_done_o); end
        vectors++;
        if (io.clint_valid_o !== 1'b0) begin miscompares++; $display("[TB] FAIL clint_valid_one_cycle got=%0h exp=0", io.clint_valid_o); end
        vectors++;
        if (io.mem_rdata_o !== 64'hFFFF_FFFF_8000_0001) begin miscompares++; $display("[TB] FAIL clint_rdata got=%0h exp=ffffffff80000001", io.mem_rdata_o); end
        vectors++;
        if (io.mem_err_o !== 1'b0) begin miscompares++; $display("[TB] FAIL clint_err got=%0h exp=0", io.mem_err_o); end
        vectors++;
        if (io.mem_stall_o !== 1'b0) begin miscompares++; $display("[TB] FAIL clint_stall_done got=%0h exp=0", io.mem_stall_o); end
        io.mem_valid_i = 1'b0;
        tick();
        vectors++;
        if (io.mem_done_o !== 1'b0) begin miscompares++; $display("[TB] FAIL clint_done_pulse got=%0h exp=0", io.mem_done_o); end
    endtask

    task automatic test_bus_store();
        io.bus_ready_i = 1'b0;
        io.bus_resp_i  = 2'd0;
        drive_req(REQ_WRITE, SIZE_B, 1'b0, 64'h0000_0000_8000_0005, 64'h0000_0000_0000_00AB);
        tick();
        // Scramble the pipeline inputs: the latched copy must be used.
        drive_req(REQ_READ, SIZE_D, 1'b1, 64'h0000_0000_9999_9990, 64'hDEAD_BEEF_DEAD_BEEF);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) io.bus_ready_i = 1'b1;
            vectors++;
            if (io.bus_valid_o !== 1'b1) begin miscompares++; $display("[TB] FAIL store_valid[%0d] got=%0h exp=1", i, io.bus_valid_o); end
            vectors++;
            if (io.bus_strb_o !== 8'h20) begin miscompares++; $display("[TB] FAIL store_strb[%0d] got=%0h exp=20", i, io.bus_strb_o); end
            vectors++;
            if (io.bus_wdata_o !== 64'h0000_AB00_0000_0000) begin miscompares++; $display("[TB] FAIL store_wdata[%0d] got=%0h exp=0000ab0000000000", i, io.bus_wdata_o); end
            vectors++;
            if (io.bus_addr_o !== 64'h0000_0000_8000_0000) begin miscompares++; $display("[TB] FAIL store_addr[%0d] got=%0h exp=80000000", i, io.bus_addr_o); end
            vectors++;
            if (io.bus_req_o !== REQ_WRITE) begin miscompares++; $display("[TB] FAIL store_req[%0d] got=%0h exp=1", i, io.bus_req_o); end
            vectors++;
            if (io.mem_stall_o !== 1'b1 || io.mem_done_o !== 1'b0) begin miscompares++; $display("[TB] FAIL store_stall[%0d] got=%0h/%0h exp=1/0", i, io.mem_stall_o, io.mem_done_o); end
            tick();
        end
        vectors++;
        if (io.mem_done_o !== 1'b1) begin miscompares++; $display("[TB] FAIL store_done got=%0h exp=1", io.mem_done_o); end
        vectors++;
        if (io.mem_rdata_o !== 64'd0) begin miscompares++; $display("[TB] FAIL store_rdata got=%0h exp=0", io.mem_rdata_o); end
        vectors++;
        if (io.bus_valid_o !== 1'b0) begin miscompares++; $display("[TB] FAIL store_valid_drop got=%0h exp=0", io.bus_valid_o); end
        io.mem_valid_i = 1'b0;
        io.bus_ready_i = 1'b0;
        tick();
    endtask

    task automatic test_bus_load();
        logic [63:0] expected [2];
        expected[0] = 64'h0000_0000_0000_F00D;
        expected[1] = 64'hFFFF_FFFF_FFFF_F00D;
        io.bus_ready_i = 1'b1;
        io.bus_resp_i  = 2'd0;
        io.bus_rdata_i = 64'hF00D_0000_0000_0000;
        for (int k = 0; k < 2; k++) begin
            drive_req(REQ_READ, SIZE_H, (k == 0), 64'h0000_0000_8000_0006, 64'hFFFF_FFFF_FFFF_FFFF);
            tick();
            vectors++;
            if (io.bus_valid_o !== 1'b1 || io.bus_strb_o !== 8'h00) begin miscompares++; $display("[TB] FAIL load_req[%0d] valid=%0h strb=%0h exp=1/00", k, io.bus_valid_o, io.bus_strb_o); end
            tick();
            vectors++;
            if (io.mem_done_o !== 1'b1) begin miscompares++; $display("[TB] FAIL load_done[%0d] got=%0h exp=1", k, io.mem_done_o); end
            vectors++;
            if (io.mem_rdata_o !== expected[k]) begin miscompares++; $display("[TB] FAIL load_rdata[%0d] got=%0h exp=%0h", k, io.mem_rdata_o, expected[k]); end
            io.mem_valid_i = 1'b0;
            tick();
        end
        io.bus_ready_i = 1'b0;
    endtask

    task automatic test_misaligned();
        io.bus_ready_i = 1'b1;
        drive_req(REQ_READ, SIZE_D, 1'b0, 64'h0000_0000_8000_0004, 64'd0);
        tick();
        vectors++;
        if (io.mem_done_o !== 1'b1) begin miscompares++; $display("[TB] FAIL misal_done got=%0h exp=1", io.mem_done_o); end
        vectors++;
        if (io.mem_err_o !== 1'b1) begin miscompares++; $display("[TB] FAIL misal_err got=%0h exp=1", io.mem_err_o); end
        vectors++;
        if (io.bus_valid_o !== 1'b0 || io.clint_valid_o !== 1'b0) begin miscompares++; $display("[TB] FAIL misal_no_req bus=%0h clint=%0h exp=0/0", io.bus_valid_o, io.clint_valid_o); end
        io.mem_valid_i = 1'b0;
        tick();
        vectors++;
        if (io.mem_done_o !== 1'b0 || io.bus_valid_o !== 1'b0) begin miscompares++; $display("[TB] FAIL misal_after done=%0h bus=%0h exp=0/0", io.mem_done_o, io.bus_valid_o); end
        io.bus_ready_i = 1'b0;
    endtask

    task automatic test_error_and_reset();
        io.bus_ready_i = 1'b1;
        io.bus_resp_i  = 2'd2;
        io.bus_rdata_i = 64'd0;
        drive_req(REQ_READ, SIZE_D, 1'b0, 64'h0000_0000_8000_0000, 64'd0);
        tick();
        tick();
        vectors++;
        if (io.mem_done_o !== 1'b1 || io.mem_err_o !== 1'b1) begin miscompares++; $display("[TB] FAIL resp_err done=%0h err=%0h exp=1/1", io.mem_done_o, io.mem_err_o); end
        io.mem_valid_i = 1'b0;
        io.bus_ready_i = 1'b0;
        io.bus_resp_i  = 2'd0;
        tick();
        drive_req(REQ_WRITE, SIZE_D, 1'b0, 64'h0000_0000_8000_0010, 64'h1234);
        tick();
        vectors++;
        if (io.bus_valid_o !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_pre_valid got=%0h exp=1", io.bus_valid_o); end
        rst = 1'b1;
        io.mem_valid_i = 1'b0;
        tick();
        vectors++;
        if (io.bus_valid_o !== 1'b0 || io.clint_valid_o !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_valids bus=%0h clint=%0h exp=0/0", io.bus_valid_o, io.clint_valid_o); end
        vectors++;
        if (io.bus_strb_o !== 8'h00 || io.bus_addr_o !== 64'd0) begin miscompares++; $display("[TB] FAIL rst_regs strb=%0h addr=%0h exp=0/0", io.bus_strb_o, io.bus_addr_o); end
        rst = 1'b0;
        io.bus_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (io.mem_done_o !== 1'b0 || io.bus_valid_o !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_no_done[%0d] done=%0h bus=%0h exp=0/0", i, io.mem_done_o, io.bus_valid_o); end
            tick();
        end
        io.bus_ready_i = 1'b0;
    endtask

    task automatic test_boundary();
        io.bus_ready_i = 1'b1;
        io.bus_rdata_i = 64'd0;
        drive_req(REQ_READ, SIZE_D, 1'b0, 64'h0000_0000_0201_0000, 64'd0);
        tick();
        vectors++;
        if (io.bus_valid_o !== 1'b1 || io.clint_valid_o !== 1'b0) begin miscompares++; $display("[TB] FAIL bound_bus bus=%0h clint=%0h exp=1/0", io.bus_valid_o, io.clint_valid_o); end
        tick();
        io.mem_valid_i = 1'b0;
        tick();
        io.clint_ready_i = 1'b1;
        io.clint_rdata_i = 64'h0000_0000_0000_0080;
        drive_req(REQ_READ, SIZE_B, 1'b0, 64'h0000_0000_0200_FFFF, 64'd0);
        tick();
        vectors++;
        if (io.clint_valid_o !== 1'b1 || io.bus_valid_o !== 1'b0) begin miscompares++; $display("[TB] FAIL bound_clint clint=%0h bus=%0h exp=1/0", io.clint_valid_o, io.bus_valid_o); end
        tick();
        vectors++;
        if (io.mem_rdata_o !== 64'hFFFF_FFFF_FFFF_FF80) begin miscompares++; $display("[TB] FAIL bound_clint_rdata got=%0h exp=ffffffffffffff80", io.mem_rdata_o); end
        io.mem_valid_i = 1'b0;
        io.bus_ready_i = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        io.bus_ready_i = 1'b1;
        io.bus_resp_i  = 2'd0;
        io.bus_rdata_i = 64'h1234_5678_8765_4321;
        drive_req(REQ_READ, SIZE_W, 1'b0, 64'h0000_0000_8000_0008, 64'd0);
        tick();
        tick();
        vectors++;
        if (io.mem_done_o !== 1'b1 || io.mem_rdata_o !== 64'hFFFF_FFFF_8765_4321) begin miscompares++; $display("[TB] FAIL b2b_first done=%0h rdata=%0h exp=1/ffffffff87654321", io.mem_done_o, io.mem_rdata_o); end
        drive_req(REQ_WRITE, SIZE_D, 1'b0, 64'h0000_0000_8000_0010, 64'h1122_3344_5566_7788);
        tick();
        vectors++;
        if (io.mem_done_o !== 1'b0 || io.bus_valid_o !== 1'b0 || io.mem_stall_o !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_gap done=%0h bus=%0h stall=%0h exp=0/0/1", io.mem_done_o, io.bus_valid_o, io.mem_stall_o); end
        tick();
        vectors++;
        if (io.bus_valid_o !== 1'b1 || io.bus_strb_o !== 8'hFF) begin miscompares++; $display("[TB] FAIL b2b_second valid=%0h strb=%0h exp=1/ff", io.bus_valid_o, io.bus_strb_o); end
        vectors++;
        if (io.bus_wdata_o !== 64'h1122_3344_5566_7788 || io.bus_addr_o !== 64'h0000_0000_8000_0010) begin miscompares++; $display("[TB] FAIL b2b_second_data wdata=%0h addr=%0h", io.bus_wdata_o, io.bus_addr_o); end
        tick();
        vectors++;
        if (io.mem_done_o !== 1'b1 || io.mem_err_o !== 1'b0 || io.mem_rdata_o !== 64'd0) begin miscompares++; $display("[TB] FAIL b2b_second_done done=%0h err=%0h rdata=%0h exp=1/0/0", io.mem_done_o, io.mem_err_o, io.mem_rdata_o); end
        io.mem_valid_i = 1'b0;
        io.bus_ready_i = 1'b0;
        tick();
    endtask

    initial begin
        io.mem_valid_i    = 1'b0;
        io.mem_req_i      = 1'b0;
        io.mem_size_i     = 2'd0;
        io.mem_unsigned_i = 1'b0;
        io.mem_addr_i     = '0;
        io.mem_wdata_i    = '0;
        io.clint_ready_i  = 1'b1;
        io.clint_rdata_i  = '0;
        io.clint_resp_i   = 2'd0;
        io.bus_ready_i    = 1'b0;
        io.bus_rdata_i    = '0;
        io.bus_resp_i     = 2'd0;
        test_reset();
        test_clint_read();
        test_bus_store();
        test_bus_load();
        test_misaligned();
        test_error_and_reset();
        test_boundary();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_dispatch.md
Name: mem_dispatch

Overview:
- Upstream of the CLINT block, inside the MEM stage.
- Accepts one load/store per transaction from the pipeline and decodes the address.
- Routes CLINT-region accesses to the CLINT port (always-ready, single-cycle) and everything else to the data-bus bridge (valid/ready, multi-cycle).
- Returns aligned, sign/zero-extended load data plus a one-cycle done pulse, and holds the pipeline stall while busy.

Parameters:
- CLINT_BASE, 64'h0000_0000_0200_0000, base of CLINT region.
- CLINT_MASK, 64'hFFFF_FFFF_FFFF_0000, region match mask: (addr & MASK) == BASE.
- ADDR_W, 64, address width.
- DATA_W, 64, data width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- mem_valid_i  in  1  pipeline request present; held until done
- mem_req_i  in  1  0=`REQ_READ, 1=`REQ_WRITE
- mem_size_i  in  2  0=byte, 1=half, 2=word, 3=double
- mem_unsigned_i  in  1  load zero-extends when 1
- mem_addr_i  in  ADDR_W  byte address
- mem_wdata_i  in  DATA_W  store data, right-justified
- mem_done_o  out  1  one-cycle completion pulse
- mem_rdata_o  out  DATA_W  extended load data, valid with done
- mem_err_o  out  1  misaligned or nonzero resp; valid with done
- mem_stall_o  out  1  mem_valid_i & ~mem_done_o
- clint_valid_o  out  1  CLINT access strobe
- clint_req_o  out  1  read/write
- clint_addr_o  out  ADDR_W  latched address
- clint_size_o  out  2  latched size
- clint_wdata_o  out  DATA_W  latched store data, unshifted
- clint_ready_i  in  1  CLINT ready (tied 1 by CLINT)
- clint_rdata_i  in  DATA_W  CLINT read data, full 64-bit register
- clint_resp_i  in  2  CLINT response, 0=OK
- bus_valid_o  out  1  bridge request valid
- bus_req_o  out  1  read/write
- bus_addr_o  out  ADDR_W  address, low 3 bits zeroed
- bus_size_o  out  2  latched size
- bus_wdata_o  out  DATA_W  store data shifted into byte lane addr[2:0]
- bus_strb_o  out  8  byte enables for the lane
- bus_ready_i  in  1  bridge accept/complete
- bus_rdata_i  in  DATA_W  64-bit aligned beat
- bus_resp_i  in  2  bridge response, 0=OK

Behaviour:
- State machine: IDLE, CLINT, BUS, RESP. Reset enters IDLE. Every output resets to 0.
- IDLE:
  - When mem_valid_i is high, latch req, size, unsigned, addr and wdata.
  - Misaligned (addr[size-1:0] != 0) -> RESP with err=1; no downstream request is issued.
  - Else CLINT-region address -> CLINT.
  - Else -> BUS.
- CLINT:
  - clint_valid_o=1 for exactly this cycle.
  - Capture clint_rdata_i and clint_resp_i when clint_ready_i is high, then go to RESP.
  - If clint_ready_i is low, stay and keep valid high.
- BUS:
  - bus_valid_o=1 and all bus_* outputs held stable until bus_valid_o & bus_ready_i.
  - On that cycle capture bus_rdata_i and bus_resp_i, then go to RESP.
  - There is no timeout.
- RESP:
  - mem_done_o=1 for exactly one cycle; next state IDLE.
  - mem_err_o = misaligned | (resp != 0).
  - A new request may be accepted on the cycle after RESP, not during it.
- Latency, accept to done pulse:
  - CLINT: 2 cycles.
  - Bus: 2 + bus wait cycles.
  - Misaligned: 1 cycle.
- Load extraction:
  - Bus path: shift rdata right by addr[2:0]*8.
  - CLINT path: rdata is already right-justified, shift by 0.
  - Truncate to 8/16/32/64 bits; sign-extend unless unsigned. Size 3 ignores unsigned.
  - Writes return mem_rdata_o=0.
- Store lanes:
  - bus_strb_o = (size mask 0x01/0x03/0x0F/0xFF) << addr[2:0].
  - bus_wdata_o = wdata << addr[2:0]*8.
  - bus_strb_o=0 for reads.
- Ignored inputs:
  - mem_valid_i dropping while in CLINT or BUS: the transaction completes anyway; no abort.
  - Input changes after IDLE acceptance are ignored (latched copy is used).
- Reset mid-transaction: synchronously returns to IDLE and deasserts all valids. The bridge must tolerate a dropped valid under reset.
- Address boundary: CLINT_BASE+0xFFFF routes to CLINT; CLINT_BASE+0x10000 routes to the bus.

Decomposition:
- defines.v gets these macros:
  - `REQ_READ/`REQ_WRITE
  - size encodings SIZE_B/H/W/D
  - CLINT_BASE/CLINT_MASK
  - resp OK code
- One combinational sub-module, mem_load_align: rdata, offset, size, unsigned -> extended data.
- Store lane shift stays inline.

Test Plan:
- CLINT read: lw addr 0x0200_BFF8 size 2, clint_rdata_i=0x1_8000_0001 -> clint_valid_o exactly 1 cycle, done 2 cycles after accept, rdata=0xFFFF_FFFF_8000_0001, err=0.
- Bus store: sb addr 0x8000_0005, wdata 0xAB, bus_ready_i delayed 3 cycles -> bus_strb_o=0x20, bus_wdata_o=0x0000_AB00_0000_0000, bus_addr_o=0x8000_0000, outputs stable while waiting, stall high until the done pulse.
- Bus load: lhu addr 0x8000_0006, bus_rdata_i=0xF00D_0000_0000_0000 -> rdata=0x0000_0000_0000_F00D. Same access as lh -> rdata=0xFFFF_FFFF_FFFF_F00D.
- Misaligned: ld addr 0x8000_0004 -> no bus_valid_o or clint_valid_o, done the next cycle with err=1.
- Error response: bus_resp_i=2 on the ready cycle -> err=1 with done. Also rst asserted while in BUS -> all valids 0 the next cycle, state IDLE, done never pulses.
- Boundary and back-to-back: addr 0x0201_0000 routes to the bus. Two requests back-to-back -> second accepted on the cycle after done, with no overlap.
